// File: rtl/sram_arbiter.sv
// N-channel request arbiter in front of the single-port SRAM.
// Fixed or round-robin selection, registered grant and read return.
module sram_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rr_mode,
  input  logic [SEL_W-1:0]         fix_sel,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        grant,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     req_err,
  output logic                     busy,
  output logic                     sram_read,
  output logic                     sram_write,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [DATA_W-1:0]        sram_wdata,
  input  logic [DATA_W-1:0]        sram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam logic [2:0] LAST = 3'(RD_LAT - 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    win_q, win_d;
  logic                wr_q, wr_d;
  logic [2:0]          cnt_q, cnt_d;

  logic [NUM_CH-1:0]   reqs;
  logic                found;
  logic [SEL_W-1:0]    sel;
  int                  idx;

  logic [NUM_CH-1:0]   grant_d;
  logic [NUM_CH-1:0]   rvalid_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                req_err_d;
  logic                sram_read_d;
  logic                sram_write_d;
  logic [ADDR_W-1:0]   sram_addr_d;
  logic [DATA_W-1:0]   sram_wdata_d;

  assign reqs = req_read | req_write;
  assign busy = (state_q != IDLE);

  // Pick the winning channel: fixed select or first requester from ptr
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    if (!rr_mode) begin
      if (int'(fix_sel) < NUM_CH) begin
        found = reqs[fix_sel];
        sel   = fix_sel;
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        idx = (int'(ptr_q) + i) % NUM_CH;
        if (reqs[idx]) begin
          found = 1'b1;
          sel   = SEL_W'(idx);
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE: begin
        if (wr_q || RD_LAT == 1) state_d = IDLE;
        else                     state_d = WAIT_RD;
      end
      WAIT_RD: if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and transaction context
  always_comb begin
    grant_d      = '0;
    rvalid_d     = '0;
    rdata_d      = rdata;
    req_err_d    = 1'b0;
    sram_read_d  = 1'b0;
    sram_write_d = 1'b0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;
    ptr_d        = ptr_q;
    win_d        = win_q;
    wr_d         = wr_q;
    cnt_d        = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d[sel] = 1'b1;
          win_d        = sel;
          wr_d         = req_write[sel];
          req_err_d    = req_read[sel] & req_write[sel];
          sram_write_d = req_write[sel];
          sram_read_d  = ~req_write[sel];
          sram_addr_d  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
          if (req_write[sel])
            sram_wdata_d = req_wdata[int'(sel)*DATA_W +: DATA_W];
          if (rr_mode)
            ptr_d = (sel == SEL_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
        end
      end
      ISSUE: begin
        if (!wr_q) begin
          if (RD_LAT == 1) begin
            rdata_d         = sram_rdata;
            rvalid_d[win_q] = 1'b1;
          end else begin
            sram_read_d = 1'b1;
            sram_addr_d = sram_addr;
            cnt_d       = 3'd1;
          end
        end
      end
      WAIT_RD: begin
        if (cnt_q == LAST) begin
          rdata_d         = sram_rdata;
          rvalid_d[win_q] = 1'b1;
        end else begin
          sram_read_d = 1'b1;
          sram_addr_d = sram_addr;
          cnt_d       = cnt_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Output and context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      rvalid     <= '0;
      rdata      <= '0;
      req_err    <= 1'b0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      grant      <= grant_d;
      rvalid     <= rvalid_d;
      rdata      <= rdata_d;
      req_err    <= req_err_d;
      sram_read  <= sram_read_d;
      sram_write <= sram_write_d;
      sram_addr  <= sram_addr_d;
      sram_wdata <= sram_wdata_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, reference arbiter model,
// scoreboard queues checked by a negedge monitor.
module tb_sram_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 3;

  logic                     clk;
  logic                     rst;
  logic                     rr_mode;
  logic [1:0]               fix_sel;
  logic [NUM_CH-1:0]        req_read;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        grant;
  logic [NUM_CH-1:0]        rvalid;
  logic [DATA_W-1:0]        rdata;
  logic                     req_err;
  logic                     busy;
  logic                     sram_read;
  logic                     sram_write;
  logic [ADDR_W-1:0]        sram_addr;
  logic [DATA_W-1:0]        sram_wdata;
  logic [DATA_W-1:0]        sram_rdata;

  sram_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .rr_mode(rr_mode), .fix_sel(fix_sel),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .rvalid(rvalid), .rdata(rdata),
    .req_err(req_err), .busy(busy),
    .sram_read(sram_read), .sram_write(sram_write),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SRAM model: data is only valid once sram_read has been
  // high for RD_LAT-1 complete cycles; before that it is corrupted.
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  int rd_cyc = 0;

  always @(posedge clk) begin
    if (sram_write) mem[sram_addr] <= sram_wdata;
    rd_cyc <= sram_read ? rd_cyc + 1 : 0;
  end

  assign sram_rdata = (sram_read && rd_cyc == RD_LAT - 1) ?
                      mem[sram_addr] : ~mem[sram_addr];

  typedef struct { int ch; logic err; } gexp_t;
  typedef struct { int ch; logic [7:0] d; } rexp_t;
  typedef struct { logic [15:0] a; logic [7:0] d; } wexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  wexp_t wq[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  gexp_t g;
  rexp_t r;
  wexp_t w;

  // Monitor: every DUT output event pops and compares one expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (grant != 0) begin
        if (gq.size() == 0) chk("unexpected_grant", 64'(grant), 0);
        else begin
          g = gq.pop_front();
          chk("grant", 64'(grant), 64'(1) << g.ch);
          chk("req_err", 64'(req_err), 64'(g.err));
        end
      end else if (req_err) begin
        chk("stray_req_err", 64'(req_err), 0);
      end
      if (rvalid != 0) begin
        if (rq.size() == 0) chk("unexpected_rvalid", 64'(rvalid), 0);
        else begin
          r = rq.pop_front();
          chk("rvalid", 64'(rvalid), 64'(1) << r.ch);
          chk("rdata", 64'(rdata), 64'(r.d));
        end
      end
      if (sram_write) begin
        if (wq.size() == 0) chk("unexpected_write", 64'(sram_addr), 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", 64'(sram_addr), 64'(w.a));
          chk("wr_data", 64'(sram_wdata), 64'(w.d));
        end
      end
      if (sram_read && sram_write)
        chk("rd_wr_overlap", 64'(1), 0);
    end
  end

  // Requester stimulus and the reference arbiter state
  logic        ch_rd [NUM_CH];
  logic        ch_wr [NUM_CH];
  logic [15:0] ch_a  [NUM_CH];
  logic [7:0]  ch_d  [NUM_CH];
  int          m_ptr = 0;
  int          order_q[$];

  task automatic clear_ch();
    for (int k = 0; k < NUM_CH; k++) begin
      ch_rd[k] = 1'b0; ch_wr[k] = 1'b0;
      ch_a[k] = '0; ch_d[k] = '0;
    end
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < NUM_CH; k++) begin
      req_read[k]  = ch_rd[k];
      req_write[k] = ch_wr[k];
      req_addr[k*ADDR_W +: ADDR_W]  = ch_a[k];
      req_wdata[k*DATA_W +: DATA_W] = ch_d[k];
    end
  endtask

  task automatic flush_all();
    gq.delete(); rq.delete(); wq.delete();
    req_read = '0; req_write = '0;
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (grant != 0) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got none expected a grant");
      flush_all();
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (!busy && gq.size() == 0 && rq.size() == 0 && wq.size() == 0) begin
        done = 1'b1; break;
      end
    end
    chk("drain", 64'(done), 1);
    if (!done) flush_all();
  endtask

  // Expected winner follows the arbitration rules directly
  function automatic int pick(input logic rr, input int fsel,
                              input logic [3:0] pend);
    if (!rr) return pend[fsel] ? fsel : -1;
    for (int i = 0; i < NUM_CH; i++)
      if (pend[(m_ptr + i) % NUM_CH]) return (m_ptr + i) % NUM_CH;
    return -1;
  endfunction

  task automatic run_batch(input logic rr, input int fsel);
    logic [3:0] pend;
    int         wn;
    bit         got;
    int         busy_hi;
    rr_mode = rr;
    fix_sel = 2'(fsel);
    for (int k = 0; k < NUM_CH; k++) pend[k] = ch_rd[k] | ch_wr[k];
    order_q.delete();
    drive_reqs();
    for (int it = 0; it < NUM_CH; it++) begin
      wn = pick(rr, fsel, pend);
      if (wn < 0) break;
      gq.push_back('{wn, ch_rd[wn] & ch_wr[wn]});
      if (ch_wr[wn]) begin
        ref_mem[ch_a[wn]] = ch_d[wn];
        wq.push_back('{ch_a[wn], ch_d[wn]});
      end else begin
        rq.push_back('{wn, ref_mem[ch_a[wn]]});
      end
      if (rr) m_ptr = (wn + 1) % NUM_CH;
      wait_grant(got);
      if (!got) return;
      order_q.push_back(wn);
      pend[wn] = 1'b0;
      req_read[wn] = 1'b0;
      req_write[wn] = 1'b0;
    end
    wait_idle();
    if (pend != 0) begin
      busy_hi = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (busy) busy_hi++;
      end
      chk("starved_busy", 64'(busy_hi), 0);
      req_read = '0;
      req_write = '0;
    end
  endtask

  task automatic read_timed(input int ch, input logic [15:0] a);
    bit got;
    int lat;
    int rd_hi;
    clear_ch();
    ch_rd[ch] = 1'b1; ch_a[ch] = a;
    rr_mode = 1'b0; fix_sel = 2'(ch);
    gq.push_back('{ch, 1'b0});
    rq.push_back('{ch, ref_mem[a]});
    drive_reqs();
    wait_grant(got);
    if (!got) return;
    req_read = '0;
    chk("issue_addr", 64'(sram_addr), 64'(a));
    rd_hi = sram_read ? 1 : 0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (rvalid != 0) begin lat = c; break; end
      if (sram_read) rd_hi++;
    end
    chk("rvalid_latency", 64'(lat), 64'(RD_LAT));
    chk("sram_read_cycles", 64'(rd_hi), 64'(RD_LAT));
    wait_idle();
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({grant, rvalid, rdata, req_err, busy,
                sram_read, sram_write, sram_addr, sram_wdata});
  endfunction

  initial begin
    bit got;
    int rv_seen;
    int op;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    rst = 1'b1; rr_mode = 1'b0; fix_sel = '0;
    req_read = '0; req_write = '0;
    req_addr = '0; req_wdata = '0;
    clear_ch();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;

    // Reset in the middle of a read drops it
    clear_ch();
    ch_rd[0] = 1'b1; ch_a[0] = 16'h0020;
    rr_mode = 1'b0; fix_sel = 2'd0;
    gq.push_back('{0, 1'b0});
    drive_reqs();
    wait_grant(got);
    req_read = '0;
    @(posedge clk); #1;
    chk("busy_mid_read", 64'(busy), 1);
    chk("sram_read_mid_read", 64'(sram_read), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_read_outputs", all_outs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0;
    rv_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rvalid != 0 || busy) rv_seen++;
    end
    chk("no_rvalid_after_reset", 64'(rv_seen), 0);

    // Fixed mode: ch1 write then read back
    clear_ch();
    ch_wr[1] = 1'b1; ch_a[1] = 16'h0005; ch_d[1] = 8'hFF;
    run_batch(1'b0, 1);
    read_timed(1, 16'h0005);
    chk("fixed_readback", 64'(rdata), 64'hFF);

    // Fixed mode: selected channel idle, others starve
    clear_ch();
    ch_wr[0] = 1'b1; ch_a[0] = 16'h0001; ch_d[0] = 8'h11;
    ch_rd[3] = 1'b1; ch_a[3] = 16'h0002;
    run_batch(1'b0, 2);

    // Round-robin: all four channels write addr k data k
    clear_ch();
    for (int k = 0; k < NUM_CH; k++) begin
      ch_wr[k] = 1'b1; ch_a[k] = 16'(k); ch_d[k] = 8'(k);
    end
    run_batch(1'b1, 0);
    chk("rr_count", 64'(order_q.size()), 4);
    for (int k = 0; k < order_q.size(); k++)
      chk("rr_order", 64'(order_q[k]), 64'(k));
    run_batch(1'b1, 0);
    if (order_q.size() > 0) chk("rr_wrap", 64'(order_q[0]), 0);
    else chk("rr_wrap_missing", 64'(order_q.size()), 1);
    for (int k = 0; k < NUM_CH; k++)
      chk("sram_dump", 64'(mem[k]), 64'(k));

    // Conflict: read and write together on the winner
    clear_ch();
    ch_rd[2] = 1'b1; ch_wr[2] = 1'b1;
    ch_a[2] = 16'h0010; ch_d[2] = 8'hA5;
    run_batch(1'b0, 2);
    chk("conflict_write", 64'(mem[16]), 64'hA5);

    // Random traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      clear_ch();
      for (int k = 0; k < NUM_CH; k++) begin
        op = $urandom_range(0, 7);
        ch_rd[k] = (op == 1 || op == 2 || op == 3 || op == 7);
        ch_wr[k] = (op == 4 || op == 5 || op == 6 || op == 7);
        ch_a[k]  = 16'($urandom_range(0, 15));
        ch_d[k]  = 8'($urandom);
      end
      run_batch(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
